// File: rtl/itof_pipe.sv
// Signed 32-bit integer to IEEE-754 binary32 converter, round-to-nearest-even.
// Three registered stages (magnitude, normalise, round) with valid/ready flow control.
module itof_pipe (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] x,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] y,
   output logic        out_valid,
   input  logic        out_ready
);

   logic        v1_q, v1_d, s1_q, s1_d;
   logic [31:0] a1_q, a1_d;
   logic        v2_q, v2_d, s2_q, s2_d;
   logic [31:0] n2_q, n2_d;
   logic [7:0]  e2_q, e2_d;
   logic        v3_q, v3_d;
   logic [31:0] y_q, y_d;

   logic        ld1, ld2, ld3;
   logic [4:0]  lz;
   logic [22:0] frac, frac_r;
   logic        carry, rnd_up;
   logic [7:0]  e_r;
   logic [31:0] res;

   // Load enables chain combinationally back from out_ready.
   always_comb begin
      ld3 = !v3_q || out_ready;
      ld2 = !v2_q || ld3;
      ld1 = !v1_q || ld2;
   end

   always_comb begin
      v1_d = v1_q;
      s1_d = s1_q;
      a1_d = a1_q;
      if (ld1) begin
         v1_d = in_valid;
         s1_d = x[31];
         a1_d = x[31] ? (~x + 32'd1) : x;
      end
   end

   always_comb begin
      lz = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (a1_q[i]) lz = 5'(31 - i);
      end
      v2_d = v2_q;
      s2_d = s2_q;
      n2_d = n2_q;
      e2_d = e2_q;
      if (ld2) begin
         v2_d = v1_q;
         s2_d = s1_q;
         n2_d = a1_q << lz;
         e2_d = 8'd158 - {3'b000, lz};
      end
   end

   // n2_q[31] is clear only for a zero operand.
   always_comb begin
      frac            = n2_q[30:8];
      rnd_up          = n2_q[7] && ((|n2_q[6:0]) || frac[0]);
      {carry, frac_r} = {1'b0, frac} + {23'd0, rnd_up};
      e_r             = e2_q + {7'd0, carry};
      res             = n2_q[31] ? {s2_q, e_r, frac_r} : 32'h0000_0000;
      v3_d            = ld3 ? v2_q : v3_q;
      y_d             = (ld3 && v2_q) ? res : y_q;
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         v1_q <= 1'b0;
         s1_q <= 1'b0;
         a1_q <= 32'h0;
         v2_q <= 1'b0;
         s2_q <= 1'b0;
         n2_q <= 32'h0;
         e2_q <= 8'h0;
         v3_q <= 1'b0;
         y_q  <= 32'h0;
      end else begin
         v1_q <= v1_d;
         s1_q <= s1_d;
         a1_q <= a1_d;
         v2_q <= v2_d;
         s2_q <= s2_d;
         n2_q <= n2_d;
         e2_q <= e2_d;
         v3_q <= v3_d;
         y_q  <= y_d;
      end
   end

   assign in_ready  = ld1;
   assign y         = y_q;
   assign out_valid = v3_q;

endmodule

// File: doc/itof_pipe.md
Name: itof_pipe

Overview:
- Converts a signed 32-bit two's-complement integer to an IEEE-754 single-precision float. This is the int-to-float counterpart of the FPU's float-to-int converter.
- Result rounding is round-to-nearest-even.
- 3-stage pipeline with valid/ready handshakes on both sides. It sits between the integer register read port and the FPU writeback arbiter.

Parameters:
- None. Widths are fixed: 32-bit integer in, binary32 out.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  asynchronous active-high reset. Asserted = 1; the name is kept for codebase consistency.
- x  input  32  signed integer operand
- in_valid  input  1  x is valid this cycle
- in_ready  output  1  pipeline accepts x this cycle. Transfer occurs when in_valid && in_ready.
- y  output  32  float result {sign, exp[7:0], frac[22:0]}
- out_valid  output  1  y holds a result
- out_ready  input  1  consumer accepts y. Transfer occurs when out_valid && out_ready.

Behaviour:
- Reset (async, rstn=1): all stage valid flags cleared; y=32'h0; out_valid=0. in_ready=1 whenever the pipeline is empty, including during reset.
- Stage S1, on accept:
  - Register s = x[31].
  - Register a = s ? (~x + 1) : x, as a 32-bit unsigned magnitude.
  - x=32'h80000000 gives a=32'h80000000, interpreted unsigned as 2^31.
- Stage S2:
  - lz = leading-zero count of a (0..31; a=0 flagged as zero).
  - n = a << lz, so n[31]=1 for nonzero a.
  - e = 8'd158 - lz.
- Stage S3:
  - frac = n[30:8]; g = n[7]; st = |n[6:0].
  - Round up when g && (st || frac[0]).
  - If frac rounds from all-ones to 0, e increments by 1.
  - Result y = {s, e, frac_rounded}.
- Zero input: y=32'h00000000 (+0.0, never -0.0).
- Exponent never exceeds 158 after rounding; no overflow, inf or NaN output is possible.
- Latency: exactly 3 cycles from accept to out_valid with out_ready held high. Throughput is 1 result per cycle.
- Backpressure:
  - Each stage register loads when its own valid is 0 or its downstream stage advances this cycle.
  - Stage 3 advances when out_valid && out_ready.
  - in_ready = !v1 || stage-2 load enable, where v1 is stage 1's valid flag. The chain is combinational from out_ready; no skid buffer.
- Stall: when out_valid=1 and out_ready=0, y and out_valid hold stable; no result is dropped or duplicated.
- Up to 3 results may be in flight. With a full pipeline and out_ready=0, in_ready=0.
- Full pipeline with out_ready=1: a simultaneous output transfer and input accept in the same cycle is legal. Occupancy stays 3.
- Bubbles: a stage with valid=0 does not block upstream. Data registers of invalid stages are don't-care, but the y port holds its last value.
- Reset mid-operation: all in-flight results are discarded and no output occurs after reset deasserts until new inputs are accepted.

Test Plan:
- Basic values, out_ready=1, back-to-back inputs:
  - x=1 → 32'h3F800000
  - x=-1 (32'hFFFFFFFF) → 32'hBF800000
  - x=0 → 32'h00000000
  - Each result appears exactly 3 cycles after its accept, one per cycle.
- Extremes:
  - x=32'h80000000 → 32'hCF000000
  - x=32'h7FFFFFFF → 32'h4F000000 (round-up carries into the exponent)
  - x=32'h00FFFFFF → 32'h4B7FFFFF (exact)
- Round-to-nearest-even ties:
  - x=32'h01000001 → 32'h4B800000 (ties down to even)
  - x=32'h01000003 → 32'h4B800002 (ties up to even)
  - x=-32'h01000003 → 32'hCB800002
- Backpressure:
  - Issue 5 inputs with out_ready=0: exactly 3 are accepted, then in_ready=0, and y is stable from the first result.
  - Raise out_ready: 5 results appear in order, with none lost or duplicated.
- Random valid/ready toggling on both sides, 10k random x: every output matches a reference model ($itor-based or C cast) in order.
- Assert rstn for 1 cycle with 2 results in flight: out_valid=0 and y=0 immediately (async). No stale result appears afterwards; the next accepted x appears 3 cycles later.
